// File: rtl/axi_ddr_slave_bridge.sv
// axi_ddr_slave_bridge: AXI4 slave converting 128-bit INCR bursts into simple_ddr word accesses
// Ports: clk/rst_n (async active-low); AXI AW/W/B and AR/R slave channels (s_*);
// simple_ddr write side wr_* (data, mask, word address, strobes, busy) and
// read side rd_* (word address + strobe, FIFO pop rd_en, returned rd_data/rd_valid).
module axi_ddr_slave_bridge #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic                  wr_busy,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [STRB_WIDTH-1:0] wr_datamask,
  output logic [31:0]           wr_addr,
  output logic                  wr_en,
  output logic                  wr_addr_en,
  input  logic                  wr_ack,
  input  logic                  rd_busy,
  output logic [31:0]           rd_addr,
  output logic                  rd_addr_en,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  input  logic                  rd_ack
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} r_state_t;
  w_state_t              w_state;
  r_state_t              r_state;
  logic [ID_WIDTH-1:0]   w_id, r_id;
  logic [31:0]           w_addr, r_addr;
  logic [7:0]            w_len, w_cnt, r_len, iss_cnt, out_cnt;
  logic [8:0]            rx_cnt;
  logic                  en_q, wp, rp, pop;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] skid [2];
  logic                  unused_ok;
  assign unused_ok = &{1'b0, wr_ack, rd_ack, s_awburst, s_arburst, s_wlast};
  assign s_wready  = (w_state == W_DATA) && !wr_busy;
  assign s_bid     = w_id;
  assign s_bresp   = 2'b00;
  assign s_rid     = r_id;
  assign s_rresp   = 2'b00;
  assign s_rvalid  = occ != 2'd0;
  assign s_rdata   = skid[rp];
  assign s_rlast   = s_rvalid && (out_cnt == r_len);
  assign pop       = s_rvalid && s_rready;
  // Pop only while the beat can still be useful and the skid has room for
  // everything already requested (including last cycle's pop still in flight).
  assign rd_en = (r_state != R_IDLE) && (rx_cnt + 9'(en_q) <= {1'b0, r_len}) &&
                 (occ + 2'(en_q) < 2'd2);
  // Write path: one simple_ddr write per accepted beat; the length counter ends the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= W_IDLE;
      s_awready   <= 1'b0;
      s_bvalid    <= 1'b0;
      w_id        <= '0;
      w_addr      <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      wr_en       <= 1'b0;
      wr_addr_en  <= 1'b0;
      wr_data     <= '0;
      wr_datamask <= '0;
      wr_addr     <= '0;
    end else begin
      wr_en      <= 1'b0;
      wr_addr_en <= 1'b0;
      case (w_state)
        W_IDLE:
          if (s_awvalid && s_awready) begin
            w_id      <= s_awid;
            w_addr    <= 32'(s_awaddr >> 4);
            w_len     <= s_awlen;
            w_cnt     <= '0;
            s_awready <= 1'b0;
            w_state   <= W_DATA;
          end else s_awready <= 1'b1;
        W_DATA:
          if (s_wvalid && s_wready) begin
            wr_en       <= 1'b1;
            wr_addr_en  <= 1'b1;
            wr_data     <= s_wdata;
            wr_datamask <= ~s_wstrb;
            wr_addr     <= w_addr;
            w_addr      <= w_addr + 32'd1;
            w_cnt       <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              s_bvalid <= 1'b1;
              w_state  <= W_RESP;
            end
          end
        W_RESP:
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            w_state   <= W_IDLE;
          end
        default: w_state <= W_IDLE;
      endcase
    end
  end
  // Read path: issue per-beat addresses, then drain returned data through a 2-entry skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      s_arready  <= 1'b0;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      iss_cnt    <= '0;
      out_cnt    <= '0;
      rx_cnt     <= '0;
      rd_addr    <= '0;
      rd_addr_en <= 1'b0;
      en_q       <= 1'b0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      occ        <= '0;
      skid[0]    <= '0;
      skid[1]    <= '0;
    end else begin
      rd_addr_en <= 1'b0;
      en_q       <= rd_en;
      occ        <= occ + 2'(rd_valid) - 2'(pop);
      if (rd_valid) begin
        skid[wp] <= rd_data;
        wp       <= ~wp;
        rx_cnt   <= rx_cnt + 9'd1;
      end
      if (pop) begin
        rp      <= ~rp;
        out_cnt <= out_cnt + 8'd1;
      end
      case (r_state)
        R_IDLE:
          if (s_arvalid && s_arready) begin
            r_id      <= s_arid;
            r_addr    <= 32'(s_araddr >> 4);
            r_len     <= s_arlen;
            iss_cnt   <= '0;
            out_cnt   <= '0;
            rx_cnt    <= '0;
            s_arready <= 1'b0;
            r_state   <= R_ISSUE;
          end else s_arready <= 1'b1;
        R_ISSUE:
          if (!rd_busy) begin
            rd_addr_en <= 1'b1;
            rd_addr    <= r_addr;
            r_addr     <= r_addr + 32'd1;
            iss_cnt    <= iss_cnt + 8'd1;
            if (iss_cnt == r_len) r_state <= R_DRAIN;
          end
        R_DRAIN:
          if (pop && out_cnt == r_len) begin
            s_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ddr_slave_bridge.sv
// tb_axi_ddr_slave_bridge: table-driven and scoreboard bench for axi_ddr_slave_bridge
`define CHK(n, a, e) chk(n, 128'(a), 128'(e))
module tb_axi_ddr_slave_bridge;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [3:0]   s_awid = 0, s_arid = 0, s_bid, s_rid;
  logic [31:0]  s_awaddr = 0, s_araddr = 0, wr_addr, rd_addr;
  logic [7:0]   s_awlen = 0, s_arlen = 0;
  logic [1:0]   s_awburst = 0, s_arburst = 0, s_bresp, s_rresp;
  logic         s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready;
  logic         s_bvalid, s_bready = 1, s_arvalid = 0, s_arready;
  logic         s_rlast, s_rvalid, s_rready = 1;
  logic [127:0] s_wdata = 0, s_rdata, wr_data, rd_data = 0;
  logic [15:0]  s_wstrb = 0, wr_datamask;
  logic         wr_busy = 0, wr_en, wr_addr_en, rd_busy = 0, rd_addr_en, rd_en, rd_valid = 0;
  axi_ddr_slave_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_busy(wr_busy), .wr_data(wr_data), .wr_datamask(wr_datamask), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_addr_en(wr_addr_en), .wr_ack(1'b0),
    .rd_busy(rd_busy), .rd_addr(rd_addr), .rd_addr_en(rd_addr_en), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ack(1'b0)
  );
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [127:0] fdata(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A5A5A, a + 32'h11111111};
  endfunction
  typedef struct { logic [31:0] a; logic [127:0] d; logic [15:0] m; } wexp_t;
  typedef struct { logic [127:0] d; logic [3:0] id; logic last; } rexp_t;
  typedef struct { logic [31:0] a; int rdy; } pend_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; logic [15:0] strb;
                   logic [31:0] exp_wa; logic [15:0] exp_mask; int busy_beat; bit early; } wvec_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; logic [31:0] exp_ra; } rvec_t;
  wexp_t wq[$];
  rexp_t rq[$];
  logic [31:0] raq[$];
  pend_t pend[$];
  wexp_t we;
  rexp_t re;
  logic [31:0] ra;
  logic en_s = 0, ae_s = 0;
  logic [31:0] a_s = 0;
  int cyc = 0, stall_cnt = 0, stall_vld = 0, r_beats = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend.delete();
      rd_valid <= 0;
    end else begin
      rd_valid <= 0;
      if (ae_s) pend.push_back('{a_s, cyc + 3});
      if (en_s && pend.size() > 0 && pend[0].rdy <= cyc) begin
        rd_valid <= 1;
        rd_data  <= fdata(pend[0].a);
        void'(pend.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    en_s = rd_en;
    ae_s = rd_addr_en;
    a_s  = rd_addr;
    if (stall_cnt > 0) begin
      s_rready = 0;
      stall_cnt--;
    end else s_rready = 1;
    if (!s_rready && rd_valid) stall_vld++;
    if (rst_n && s_rvalid && s_rready) begin
      if (rq.size() == 0) `CHK("r_unexpected", rq.size(), 1);
      else begin
        re = rq.pop_front();
        n_chk++;
        if (s_rdata === re.d) n_pass++;
        else $display("FAIL rdata: got %0h expected %0h", s_rdata, re.d);
        n_chk++;
        if (s_rid === re.id) n_pass++;
        else $display("FAIL rid: got %0h expected %0h", s_rid, re.id);
        n_chk++;
        if (s_rlast === re.last) n_pass++;
        else $display("FAIL rlast: got %0h expected %0h", s_rlast, re.last);
        `CHK("rresp", s_rresp, 0);
        r_beats++;
      end
    end
    if (rst_n && rd_addr_en) begin
      if (raq.size() == 0) `CHK("rd_addr_unexpected", raq.size(), 1);
      else begin
        ra = raq.pop_front();
        n_chk++;
        if (rd_addr === ra) n_pass++;
        else $display("FAIL rd_addr: got %0h expected %0h", rd_addr, ra);
      end
    end
    if (rst_n && wr_en) begin
      `CHK("wr_addr_en", wr_addr_en, 1);
      if (wq.size() == 0) `CHK("wr_unexpected", wq.size(), 1);
      else begin
        we = wq.pop_front();
        n_chk++;
        if (wr_addr === we.a) n_pass++;
        else $display("FAIL wr_addr: got %0h expected %0h", wr_addr, we.a);
        n_chk++;
        if (wr_data === we.d) n_pass++;
        else $display("FAIL wr_data: got %0h expected %0h", wr_data, we.d);
        n_chk++;
        if (wr_datamask === we.m) n_pass++;
        else $display("FAIL wr_datamask: got %0h expected %0h", wr_datamask, we.m);
      end
    end
  end
  task automatic wr_burst(input wvec_t v);
    int t;
    @(negedge clk);
    s_awaddr = v.addr; s_awlen = v.len; s_awid = v.id; s_awburst = 2'b01; s_awvalid = 1;
    t = 0;
    while (!s_awready && t < 200) begin @(negedge clk); t++; end
    `CHK("aw_handshake", s_awready, 1);
    @(negedge clk);
    s_awvalid = 0;
    for (int i = 0; i <= int'(v.len); i++) begin
      s_wdata = {4{32'hA5A5A5A5 ^ 32'(i)}};
      s_wstrb = v.strb;
      s_wlast = v.early ? (i == 0) : (i == int'(v.len));
      s_wvalid = 1;
      if (i == v.busy_beat) begin
        wr_busy = 1;
        repeat (3) begin #1 `CHK("wready_busy", s_wready, 0); @(negedge clk); end
        wr_busy = 0;
      end
      #1 t = 0;
      while (!s_wready && t < 200) begin @(negedge clk); t++; end
      `CHK("w_handshake", s_wready, 1);
      wq.push_back('{v.exp_wa + 32'(i), s_wdata, v.exp_mask});
      @(negedge clk);
    end
    s_wvalid = 0; s_wlast = 0;
    t = 0;
    while (!s_bvalid && t < 200) begin @(negedge clk); t++; end
    `CHK("bvalid", s_bvalid, 1);
    `CHK("bid", s_bid, v.id);
    `CHK("bresp", s_bresp, 0);
    @(negedge clk);
    `CHK("b_done", s_bvalid, 0);
  endtask
  task automatic rd_burst(input rvec_t v);
    int t;
    @(negedge clk);
    s_araddr = v.addr; s_arlen = v.len; s_arid = v.id; s_arburst = 2'b01; s_arvalid = 1;
    t = 0;
    while (!s_arready && t < 200) begin @(negedge clk); t++; end
    `CHK("ar_handshake", s_arready, 1);
    for (int i = 0; i <= int'(v.len); i++) begin
      raq.push_back(v.exp_ra + 32'(i));
      rq.push_back('{fdata(v.exp_ra + 32'(i)), v.id, i == int'(v.len)});
    end
    @(negedge clk);
    s_arvalid = 0;
    t = 0;
    while (rq.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    `CHK("r_complete", rq.size(), 0);
    @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    `CHK({tag, "_awready"}, s_awready, 0);
    `CHK({tag, "_wready"}, s_wready, 0);
    `CHK({tag, "_bvalid"}, s_bvalid, 0);
    `CHK({tag, "_arready"}, s_arready, 0);
    `CHK({tag, "_rvalid"}, s_rvalid, 0);
    `CHK({tag, "_rlast"}, s_rlast, 0);
    `CHK({tag, "_wr_en"}, {wr_en, wr_addr_en}, 0);
    `CHK({tag, "_wr_addr"}, wr_addr, 0);
    `CHK({tag, "_wr_data"}, wr_data, 0);
    `CHK({tag, "_wr_datamask"}, wr_datamask, 0);
    `CHK({tag, "_rd_strobes"}, {rd_en, rd_addr_en}, 0);
    `CHK({tag, "_rd_addr"}, rd_addr, 0);
  endtask
  wvec_t wv[4];
  rvec_t rv[3];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    wv[0] = '{32'h100,      8'd0, 4'h3, 16'hFFFF, 32'h10,       16'h0000, -1, 1'b0};
    wv[1] = '{32'h2000,     8'd3, 4'h5, 16'h00FF, 32'h200,      16'hFF00,  1, 1'b0};
    wv[2] = '{32'h12345678, 8'd1, 4'hA, 16'hF0F0, 32'h01234567, 16'h0F0F, -1, 1'b1};
    wv[3] = '{32'hFFFFFFF0, 8'd2, 4'hF, 16'h0001, 32'h0FFFFFFF, 16'hFFFE,  0, 1'b0};
    rv[0] = '{32'h40,       8'd7, 4'h2, 32'h4};
    rv[1] = '{32'h1234F,    8'd0, 4'h9, 32'h1234};
    rv[2] = '{32'hFFFFFFF0, 8'd3, 4'hE, 32'h0FFFFFFF};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    for (int i = 0; i < 4; i++) wr_burst(wv[i]);
    for (int i = 0; i < 3; i++) rd_burst(rv[i]);
    stall_vld = 0;
    fork
      rd_burst('{32'h1000, 8'd15, 4'h6, 32'h100});
      begin
        int base;
        base = r_beats;
        t = 0;
        while (r_beats < base + 3 && t < 500) begin @(negedge clk); t++; end
        `CHK("stall_start", r_beats >= base + 3, 1);
        stall_cnt = 10;
      end
    join
    `CHK("stall_fill", stall_vld <= 2, 1);
    fork
      wr_burst('{32'h5000, 8'd5, 4'hC, 16'hFFFF, 32'h500, 16'h0000, 2, 1'b0});
      rd_burst('{32'h8000, 8'd5, 4'h3, 32'h800});
      repeat (4) begin
        repeat (2) @(negedge clk);
        rd_busy = 1;
        repeat (2) @(negedge clk);
        rd_busy = 0;
      end
    join
    @(negedge clk);
    s_awaddr = 32'h300; s_awlen = 3; s_awid = 4'h7; s_awvalid = 1;
    t = 0;
    while (!s_awready && t < 200) begin @(negedge clk); t++; end
    `CHK("rst_aw_handshake", s_awready, 1);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 1; s_wstrb = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      s_wdata = {4{32'h0BAD0000 + 32'(i)}};
      #1 `CHK("rst_wready", s_wready, 1);
      wq.push_back('{32'h30 + 32'(i), s_wdata, 16'h0000});
      @(negedge clk);
    end
    s_wvalid = 0;
    #2 `CHK("rst_beats_seen", wq.size(), 0);
    rst_n = 0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1;
    wq.delete(); rq.delete(); raq.delete();
    repeat (2) @(negedge clk);
    wr_burst('{32'h400, 8'd0, 4'h1, 16'h0F0F, 32'h40, 16'hF0F0, -1, 1'b0});
    rd_burst('{32'h20, 8'd1, 4'h4, 32'h2});
    repeat (3) @(negedge clk);
    `CHK("final_wq_empty", wq.size(), 0);
    `CHK("final_raq_empty", raq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_ddr_slave_bridge.md
Name: axi_ddr_slave_bridge

Overview:
AXI4 slave front-end that sits directly upstream of simple_ddr. It accepts 128-bit AXI4 INCR bursts from the AXI master and converts each write beat into one simple_ddr write (address and data issued together). It converts each read burst into per-beat read addresses, then drains simple_ddr read data back onto the R channel. The write path and read path are independent FSMs, and each allows one outstanding burst.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI byte-address width
DATA_WIDTH, 128, data width (fixed; matches simple_ddr)
STRB_WIDTH, 16, DATA_WIDTH/8

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
s_awid/awaddr/awlen/awburst/awvalid  in  ID/ADDR/8/2/1  AW channel
s_awready  out  1  AW ready
s_wdata/wstrb/wlast/wvalid  in  128/16/1/1  W channel
s_wready  out  1  W ready
s_bid/bresp/bvalid  out  ID/2/1  B channel
s_bready  in  1  B ready
s_arid/araddr/arlen/arburst/arvalid  in  ID/ADDR/8/2/1  AR channel
s_arready  out  1  AR ready
s_rid/rdata/rresp/rlast/rvalid  out  ID/128/2/1/1  R channel
s_rready  in  1  R ready
wr_busy  in  1  simple_ddr write FIFOs full
wr_data  out  128  write data
wr_datamask  out  16  per-byte mask (1 = do not write)
wr_addr  out  32  DDR word address
wr_en, wr_addr_en  out  1  write strobes, always asserted together
wr_ack  in  1  unused; tied off internally
rd_busy  in  1  simple_ddr read FIFOs full
rd_addr  out  32  DDR word address
rd_addr_en  out  1  read address strobe
rd_en  out  1  pop simple_ddr read-data FIFO
rd_data  in  128  read data
rd_valid  in  1  rd_data valid, exactly 1 cycle after an rd_en hitting a non-empty FIFO
rd_ack  in  1  unused

Behaviour:
- Reset values: all outputs 0, including every *ready, *valid, wr_*/rd_* strobes, addresses and data. Reset mid-burst abandons the burst; no pending beats survive.
- Address rule: DDR word addr = AXI byte addr >> 4, zero-extended to 32 bits. The word address increments by 1 per beat. awburst/arburst is ignored (all bursts treated as INCR). Size is always 16 bytes. No 4KB-boundary check.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id, word addr and len; go to W_DATA.
  - W_DATA: wready = ~wr_busy. On each W handshake, register outputs for exactly one cycle: wr_en=wr_addr_en=1, wr_data=wdata, wr_datamask=~wstrb, wr_addr=current addr. Then increment addr and the beat counter.
  - Leave W_DATA when beat count reaches awlen+1. A wlast asserted early or late is ignored; the length counter rules.
  - W_RESP: bvalid=1, bresp=2'b00, bid=latched id. When bready, go to W_IDLE.
- Read issue FSM states: R_IDLE, R_ISSUE, R_DRAIN.
  - R_IDLE: arready=1. On AR handshake, latch id, addr and len; go to R_ISSUE.
  - R_ISSUE: each cycle with ~rd_busy, pulse rd_addr_en with rd_addr=current addr and increment. After arlen+1 addresses, go to R_DRAIN.
  - R_DRAIN: wait until arlen+1 beats have been delivered on R, then return to R_IDLE.
- Read return path: 2-entry R skid FIFO.
  - rd_en=1 when the state is R_ISSUE or R_DRAIN, and (received beats + rd_en in flight) < arlen+1, and (skid occupancy + rd_en of previous cycle) < 2.
  - An rd_en on an empty simple_ddr FIFO returns nothing; the bridge simply retries.
  - Each rd_valid pushes rd_data into the skid FIFO.
  - R output: rvalid = skid non-empty, rresp=00, rid=latched id. rlast=1 on beat index arlen.
  - Push and pop in the same cycle are allowed. The skid FIFO never overflows.
- Read and write paths run concurrently with no ordering between them.

Test Plan:
- Single write: awaddr=0x100, awlen=0, wdata=0xA5..., wstrb=0xFFFF -> one cycle wr_en=wr_addr_en=1, wr_addr=0x10, wr_datamask=0x0000; then bvalid with bresp=0, bid echoed.
- Burst write with backpressure: awaddr=0x2000, awlen=3, wr_busy=1 for cycles 2-4 -> wready low while busy; wr_addr 0x200..0x203 in order; exactly 4 strobes; wstrb=0x00FF gives datamask=0xFF00.
- Burst read: araddr=0x40, arlen=7, model returns data 3 cycles after each rd_addr_en -> rd_addr 0x4..0xB; 8 R beats in order; rlast only on beat 7.
- R backpressure: rready=0 for 10 cycles mid-burst -> rd_en stops within 2 beats; no data loss; skid occupancy ≤2.
- Concurrent read and write bursts plus rd_busy pulses -> both complete with correct data and ids.
- Reset asserted mid-burst -> all outputs 0 immediately; after release a fresh awlen=0 write completes normally.
